gpio_output_stage: RTL
======================

// Module: gpio_output_stage
// PURPOSE
//  Per-pin GPIO output driver: the drive-side counterpart of the GPIO input stage. Accepts level commands
//  (set/clear/toggle/write) and timed single pulses via valid/ready, holds the pin level, and drives
//  registered pad output/output-enable with push-pull or open-drain encoding. Emits registered edge
//  flags on the driven level, mirroring the input side's r_edge/f_edge semantics.
// PARAMETERS
//  PulseCntWidth  16    width of pulse length / down-counter
//  ResetValue     1'b0  pin level after reset
// PORTS
//  clk_i          in   1              clock
//  rst_i          in   1              synchronous, active-high reset
//  en_i           in   1              stage enable; low freezes FSM/counter, blocks commands
//  cmd_valid_i    in   1              command valid
//  cmd_ready_o    out  1              command ready
//  cmd_op_i       in   3              gpio_out_pkg::op_e: NOP,SET,CLR,TOGGLE,WRITE,PULSE
//  cmd_data_i     in   1              level for WRITE; active level for PULSE
//  pulse_len_i    in   PulseCntWidth  PULSE duration in enabled cycles
//  oe_i           in   1              direction: 1 = output
//  open_drain_i   in   1              1 = open-drain encoding
//  gpio_out_o     out  1              pad output value (registered)
//  gpio_oe_o      out  1              pad output enable (registered)
//  busy_o         out  1              high while in PULSE state
//  done_o         out  1              1-cycle strobe at pulse end
//  r_edge_o       out  1              1-cycle strobe, pad level rose
//  f_edge_o       out  1              1-cycle strobe, pad level fell
// BEHAVIOUR
//  - Reset (rst_i=1 at edge, wins over all): level_q=ResetValue, state=IDLE, cnt=0, saved=0,
//    gpio_out_o=0, gpio_oe_o=0, busy_o=0, done_o=0, r_edge_o=0, f_edge_o=0. Mid-pulse reset: no done_o.
//  - cmd_ready_o = en_i & (state==IDLE) & ~rst_i. Accept = cmd_valid_i & cmd_ready_o at rising edge.
//  - Ops on accept: SET level_q<=1; CLR <=0; TOGGLE <=~level_q; WRITE <=cmd_data_i; NOP no effect;
//    undefined opcodes behave as NOP.
//  - PULSE, pulse_len_i=L>=1: saved<=level_q, level_q<=cmd_data_i, cnt<=L-1, state<=PULSE.
//    In PULSE with en_i: cnt!=0 -> cnt--; cnt==0 -> level_q<=saved, state<=IDLE, done_o=1 next cycle.
//    Active level held exactly L enabled cycles. en_i low freezes cnt/state (pulse stretches).
//  - PULSE with L=0: no level change, state stays IDLE, done_o=1 the following cycle.
//  - PULSE with cmd_data_i==level_q: runs full L cycles, no pad edge, done_o still asserted.
//  - Pad stage, every cycle regardless of en_i (1-cycle latency from level_q):
//    push-pull (open_drain_i=0): gpio_out_o<=level_q, gpio_oe_o<=oe_i.
//    open-drain (open_drain_i=1): gpio_out_o<=0, gpio_oe_o<=oe_i & ~level_q.
//  - Edge flags registered with the pad stage, on driven level d=level_q vs previous d_q:
//    r_edge_o<=d&~d_q, f_edge_o<=~d&d_q; independent of oe_i/open_drain_i; d_q resets to ResetValue.
//  - busy_o = (state==PULSE), combinational from state reg.
//  - Latency: accept at edge N -> level_q at N -> gpio_out_o/edge flag at N+1.
// STRUCTURE
//  - gpio_out_pkg: op_e enum (NOP=0,SET=1,CLR=2,TOGGLE=3,WRITE=4,PULSE=5), state_e {IDLE,PULSE}.
//  - Single module, no sub-modules: FSM + down-counter + pad/edge register stage.
// TESTING
//  - Reset: hold rst_i 2 cycles -> all outputs 0, level_q=ResetValue, cmd_ready_o=1 once en_i=1.
//  - SET, TOGGLE, TOGGLE, WRITE 1 back-to-back -> gpio_out_o 1,0,1,1 at N+1..N+4; r/f_edge strobes match.
//  - PULSE data=1 L=3 from level 0 -> out high exactly 3 cycles, busy_o 3 cycles, ready low, done_o 1 cycle.
//  - PULSE L=5, en_i low 2 cycles mid-pulse -> high 7 cycles total; commands during pulse not accepted.
//  - Open-drain, level 0/1 -> gpio_oe_o 1/0, gpio_out_o 0; oe_i=0 -> gpio_oe_o 0, edge flags still pulse.
//  - rst_i asserted at 2nd cycle of L=10 pulse -> level ResetValue, busy_o 0, no done_o afterwards.

Source files
------------

// File: rtl/gpio_out_pkg.sv
// Shared opcode and FSM state types for the GPIO output driver.
package gpio_out_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_SET    = 3'd1,
      OP_CLR    = 3'd2,
      OP_TOGGLE = 3'd3,
      OP_WRITE  = 3'd4,
      OP_PULSE  = 3'd5
   } op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_PULSE = 1'b1
   } state_e;

endpackage

// File: rtl/gpio_output_stage.sv
// Per-pin GPIO output driver: level/pulse command FSM, pulse down-counter and
// registered pad stage with push-pull/open-drain encoding and edge strobes.
module gpio_output_stage
   import gpio_out_pkg::*;
#(
   parameter int   PulseCntWidth = 16,
   parameter logic ResetValue    = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [2:0]               cmd_op_i,
   input  logic                     cmd_data_i,
   input  logic [PulseCntWidth-1:0] pulse_len_i,
   input  logic                     oe_i,
   input  logic                     open_drain_i,
   output logic                     gpio_out_o,
   output logic                     gpio_oe_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     r_edge_o,
   output logic                     f_edge_o
);

   state_e                   state_q;
   logic [PulseCntWidth-1:0] cnt_q;
   logic                     level_q, saved_q, d_q;
   logic                     out_q, oe_q, done_q, r_q, f_q;
   logic                     accept;

   assign cmd_ready_o = en_i & (state_q == ST_IDLE) & ~rst_i;
   assign accept      = cmd_valid_i & cmd_ready_o;
   assign busy_o      = (state_q == ST_PULSE);
   assign gpio_out_o  = out_q;
   assign gpio_oe_o   = oe_q;
   assign done_o      = done_q;
   assign r_edge_o    = r_q;
   assign f_edge_o    = f_q;

   // Command FSM and pulse counter; en_i low freezes everything here.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         level_q <= ResetValue;
         saved_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            case (op_e'(cmd_op_i))
               OP_SET:    level_q <= 1'b1;
               OP_CLR:    level_q <= 1'b0;
               OP_TOGGLE: level_q <= ~level_q;
               OP_WRITE:  level_q <= cmd_data_i;
               OP_PULSE: begin
                  if (pulse_len_i != '0) begin
                     saved_q <= level_q;
                     level_q <= cmd_data_i;
                     cnt_q   <= pulse_len_i - PulseCntWidth'(1);
                     state_q <= ST_PULSE;
                  end else begin
                     done_q  <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (en_i && state_q == ST_PULSE) begin
            if (cnt_q != '0) begin
               cnt_q <= cnt_q - PulseCntWidth'(1);
            end else begin
               level_q <= saved_q;
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
            end
         end
      end
   end

   // Pad and edge stage runs every cycle so direction/encoding changes apply even when disabled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q <= 1'b0;
         oe_q  <= 1'b0;
         r_q   <= 1'b0;
         f_q   <= 1'b0;
         d_q   <= ResetValue;
      end else begin
         if (open_drain_i) begin
            out_q <= 1'b0;
            oe_q  <= oe_i & ~level_q;
         end else begin
            out_q <= level_q;
            oe_q  <= oe_i;
         end
         r_q <= level_q & ~d_q;
         f_q <= ~level_q & d_q;
         d_q <= level_q;
      end
   end

endmodule
